// File: rtl/send_packet.sv
// send_packet: emits one 8-flit addressed packet per accepted request, then idles for GAP_CYCLES.
// Optional SEND_PACKET_CNT_EN adds pkt_cnt, a count of completed tail-flit transfers.
module send_packet #(
  parameter int X_SRC      = 0,
  parameter int Y_SRC      = 0,
  parameter int PKT_LEN    = 8,
  parameter int GAP_CYCLES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_x_des,
  input  logic [6:0]  req_y_des,
  output logic [31:0] flit_data,
  output logic [2:0]  flit_addr,
  output logic        flit_valid,
  input  logic        flit_ready,
`ifdef SEND_PACKET_CNT_EN
  output logic [15:0] pkt_cnt,
`endif
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  localparam logic [6:0] LP_X      = 7'(X_SRC);
  localparam logic [6:0] LP_Y      = 7'(Y_SRC);
  localparam logic [2:0] LP_LAST   = 3'(PKT_LEN - 1);
  localparam logic       LP_NOGAP  = (GAP_CYCLES == 0);
  localparam logic [3:0] LP_GAP_M1 = 4'(LP_NOGAP ? 0 : GAP_CYCLES - 1);
  state_t      r_state, w_state;
  logic        r_flit_valid, w_flit_valid;
  logic [2:0]  r_flit_addr, w_flit_addr;
  logic [31:0] r_flit_data, w_flit_data;
  logic [6:0]  r_x, w_x, r_y, w_y;
  logic [3:0]  r_gap, w_gap;
  logic        r_req_ready, w_req_ready;
  logic        r_busy, w_busy;
  logic        w_tail_xfer;
  function automatic logic [31:0] f_flit(input logic [6:0] x, input logic [6:0] y, input logic [2:0] a);
    return {x, y, LP_X, LP_Y, a == LP_LAST, a};
  endfunction
  always_comb begin
    w_state      = r_state;
    w_flit_valid = r_flit_valid;
    w_flit_addr  = r_flit_addr;
    w_flit_data  = r_flit_data;
    w_x          = r_x;
    w_y          = r_y;
    w_gap        = r_gap;
    w_req_ready  = r_req_ready;
    w_busy       = r_busy;
    w_tail_xfer  = 1'b0;
    case (r_state)
      IDLE: if (req_valid && r_req_ready) begin
        w_state      = SEND;
        w_x          = req_x_des;
        w_y          = req_y_des;
        w_flit_valid = 1'b1;
        w_flit_addr  = 3'd0;
        w_flit_data  = f_flit(req_x_des, req_y_des, 3'd0);
        w_req_ready  = 1'b0;
        w_busy       = 1'b1;
      end
      SEND: if (r_flit_valid && flit_ready) begin
        if (r_flit_addr == LP_LAST) begin
          w_tail_xfer  = 1'b1;
          w_flit_valid = 1'b0;
          w_flit_addr  = 3'd0;
          w_flit_data  = 32'd0;
          w_gap        = LP_GAP_M1;
          w_state      = LP_NOGAP ? IDLE : GAP;
          w_req_ready  = LP_NOGAP;
          w_busy       = !LP_NOGAP;
        end else begin
          w_flit_addr  = r_flit_addr + 3'd1;
          w_flit_data  = f_flit(r_x, r_y, r_flit_addr + 3'd1);
        end
      end
      GAP: begin
        w_gap       = (r_gap == 4'd0) ? r_gap : r_gap - 4'd1;
        w_state     = (r_gap == 4'd0) ? IDLE : GAP;
        w_req_ready = (r_gap == 4'd0);
        w_busy      = (r_gap != 4'd0);
      end
      default: begin
        w_state      = IDLE;
        w_flit_valid = 1'b0;
        w_flit_addr  = 3'd0;
        w_flit_data  = 32'd0;
        w_req_ready  = 1'b1;
        w_busy       = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_flit_valid <= 1'b0;
      r_flit_addr  <= 3'd0;
      r_flit_data  <= 32'd0;
      r_x          <= 7'd0;
      r_y          <= 7'd0;
      r_gap        <= 4'd0;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_flit_valid <= w_flit_valid;
      r_flit_addr  <= w_flit_addr;
      r_flit_data  <= w_flit_data;
      r_x          <= w_x;
      r_y          <= w_y;
      r_gap        <= w_gap;
      r_req_ready  <= w_req_ready;
      r_busy       <= w_busy;
    end
  end
`ifdef SEND_PACKET_CNT_EN
  logic [15:0] r_pkt_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pkt_cnt <= 16'd0;
    else if (w_tail_xfer) r_pkt_cnt <= r_pkt_cnt + 16'd1;
  end
  assign pkt_cnt = r_pkt_cnt;
`endif
  assign req_ready  = r_req_ready;
  assign flit_data  = r_flit_data;
  assign flit_addr  = r_flit_addr;
  assign flit_valid = r_flit_valid;
  assign busy       = r_busy;
endmodule

// File: tb/tb_send_packet.sv
// tb_send_packet: table-driven checks of send_packet plus hand-written reset, gap and counter sequences.
module tb_send_packet;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [6:0]  req_x_des = 7'd0;
  logic [6:0]  req_y_des = 7'd0;
  logic        flit_ready = 1'b0;
  logic        req_ready, flit_valid, busy;
  logic [31:0] flit_data;
  logic [2:0]  flit_addr;
  logic        g0_req_ready, g0_flit_valid, g0_busy;
  logic [31:0] g0_flit_data;
  logic [2:0]  g0_flit_addr;
`ifdef SEND_PACKET_CNT_EN
  logic [15:0] pkt_cnt, g0_pkt_cnt;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  send_packet #(.X_SRC(1), .Y_SRC(2), .PKT_LEN(8), .GAP_CYCLES(6)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x_des(req_x_des), .req_y_des(req_y_des), .flit_data(flit_data),
    .flit_addr(flit_addr), .flit_valid(flit_valid), .flit_ready(flit_ready),
`ifdef SEND_PACKET_CNT_EN
    .pkt_cnt(pkt_cnt),
`endif
    .busy(busy));

  send_packet #(.X_SRC(1), .Y_SRC(2), .PKT_LEN(8), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(g0_req_ready),
    .req_x_des(req_x_des), .req_y_des(req_y_des), .flit_data(g0_flit_data),
    .flit_addr(g0_flit_addr), .flit_valid(g0_flit_valid), .flit_ready(flit_ready),
`ifdef SEND_PACKET_CNT_EN
    .pkt_cnt(g0_pkt_cnt),
`endif
    .busy(g0_busy));

  typedef struct {
    logic rv; logic [6:0] x; logic [6:0] y; logic fr;
    logic ev; logic [2:0] ea; logic [31:0] ed; logic erdy; logic ebusy;
  } vec_t;
  vec_t tbl[19];

  function automatic logic [31:0] ef(input int x, input int y, input int a);
    logic [2:0] a3;
    a3 = 3'(a);
    return {7'(x), 7'(y), 7'd1, 7'd2, a3 == 3'd7, a3};
  endfunction

  function automatic vec_t mk(input int rv, input int x, input int y, input int fr,
                              input int ev, input int ea, input logic [31:0] ed,
                              input int erdy, input int ebusy);
    vec_t v;
    v.rv = 1'(rv); v.x = 7'(x); v.y = 7'(y); v.fr = 1'(fr);
    v.ev = 1'(ev); v.ea = 3'(ea); v.ed = ed; v.erdy = 1'(erdy); v.ebusy = 1'(ebusy);
    return v;
  endfunction

  task automatic chk(input string n, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", n, i, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string n);
    int k = 0;
    while (!req_ready && k < 30) begin step(); k++; end
    chk(n, k, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic send_pkt(input int x, input int y);
    wait_ready("send_wait");
    req_valid = 1'b1; req_x_des = 7'(x); req_y_des = 7'(y); flit_ready = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    int zeros, rdy_low, k;
    tbl[0] = mk(1, 3, 5, 0, 1, 0, 32'h06140820, 0, 1);
    for (int i = 1; i <= 4; i++) tbl[i] = mk(0, 0, 0, 1, 1, i, ef(3, 5, i), 0, 1);
    tbl[5] = mk(0, 0, 0, 0, 1, 4, ef(3, 5, 4), 0, 1);
    tbl[6] = mk(1, 9, 9, 0, 1, 4, ef(3, 5, 4), 0, 1);
    tbl[7] = mk(0, 0, 0, 0, 1, 4, ef(3, 5, 4), 0, 1);
    tbl[8] = mk(0, 0, 0, 1, 1, 5, ef(3, 5, 5), 0, 1);
    tbl[9] = mk(0, 0, 0, 1, 1, 6, ef(3, 5, 6), 0, 1);
    tbl[10] = mk(0, 0, 0, 1, 1, 7, 32'h0614082F, 0, 1);
    for (int i = 11; i <= 16; i++) tbl[i] = mk(0, 0, 0, 1, 0, 0, 32'd0, 0, 1);
    tbl[17] = mk(0, 0, 0, 1, 0, 0, 32'd0, 1, 0);
    tbl[18] = mk(1, 1, 2, 0, 1, 0, ef(1, 2, 0), 0, 1);

    #12;
    chk("rst_valid", -1, {31'd0, flit_valid}, 32'd0);
    chk("rst_addr", -1, {29'd0, flit_addr}, 32'd0);
    chk("rst_data", -1, flit_data, 32'd0);
    chk("rst_ready", -1, {31'd0, req_ready}, 32'd1);
    chk("rst_busy", -1, {31'd0, busy}, 32'd0);
`ifdef SEND_PACKET_CNT_EN
    chk("rst_cnt", -1, {16'd0, pkt_cnt}, 32'd0);
`endif
    @(negedge clk) rst_n = 1'b1;
    step();

    for (int i = 0; i < 19; i++) begin
      req_valid = tbl[i].rv; req_x_des = tbl[i].x; req_y_des = tbl[i].y; flit_ready = tbl[i].fr;
      step();
      chk("valid", i, {31'd0, flit_valid}, {31'd0, tbl[i].ev});
      chk("addr", i, {29'd0, flit_addr}, {29'd0, tbl[i].ea});
      chk("data", i, flit_data, tbl[i].ed);
      chk("ready", i, {31'd0, req_ready}, {31'd0, tbl[i].erdy});
      chk("busy", i, {31'd0, busy}, {31'd0, tbl[i].ebusy});
      if (i == 10) chk("g0_ready_pre", i, {31'd0, g0_req_ready}, 32'd0);
      if (i == 11) begin
        chk("g0_ready", i, {31'd0, g0_req_ready}, 32'd1);
        chk("g0_busy", i, {31'd0, g0_busy}, 32'd0);
        chk("g0_valid", i, {31'd0, g0_flit_valid}, 32'd0);
      end
    end
`ifdef SEND_PACKET_CNT_EN
    chk("cnt_one", -1, {16'd0, pkt_cnt}, 32'd1);
`endif

    req_valid = 1'b0; flit_ready = 1'b1;
    repeat (3) step();
    chk("mid_addr", -1, {29'd0, flit_addr}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", -1, {31'd0, flit_valid}, 32'd0);
    chk("arst_addr", -1, {29'd0, flit_addr}, 32'd0);
    chk("arst_busy", -1, {31'd0, busy}, 32'd0);
    chk("arst_ready", -1, {31'd0, req_ready}, 32'd1);
    chk("arst_data", -1, flit_data, 32'd0);
`ifdef SEND_PACKET_CNT_EN
    chk("arst_cnt", -1, {16'd0, pkt_cnt}, 32'd0);
`endif
    @(negedge clk) rst_n = 1'b1;
    repeat (3) step();
    chk("post_valid", -1, {31'd0, flit_valid}, 32'd0);
    chk("post_busy", -1, {31'd0, busy}, 32'd0);
    chk("post_ready", -1, {31'd0, req_ready}, 32'd1);

    req_valid = 1'b1; req_x_des = 7'd7; req_y_des = 7'd1; flit_ready = 1'b1;
    step();
    repeat (8) step();
    zeros = 0; rdy_low = 0; k = 0;
    while (!flit_valid && k < 30) begin
      zeros++;
      if (!req_ready) rdy_low++;
      step();
      k++;
    end
    chk("held_idle_cycles", -1, zeros, 32'd7);
    chk("held_ready_low", -1, rdy_low, 32'd6);
    chk("held_head", -1, flit_data, ef(7, 1, 0));
    req_valid = 1'b0;

`ifdef SEND_PACKET_CNT_EN
    rst_n = 1'b0;
    #1;
    @(negedge clk) rst_n = 1'b1;
    for (int p = 0; p < 3; p++) send_pkt(p, p + 1);
    chk("cnt_three", -1, {16'd0, pkt_cnt}, 32'd3);
    wait_ready("abandon_wait");
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("cnt_abandon", -1, {16'd0, pkt_cnt}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
